// File: rtl/dense_argmax.sv
// dense_argmax: running arg-max over a frame of NUM_NEURONS signed scores.
// Scores arrive one per beat on a valid/ready stream. After the last beat of
// a frame, the winning index and its score are presented on a result port.
// The result is held until the consumer accepts it.
module dense_argmax #(
  parameter int NUM_NEURONS = 40,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              dense_valid_i,
  input  logic [DATA_W-1:0] dense_data_i,
  output logic              dense_ready_o,
  output logic              class_valid_o,
  output logic [IDX_W-1:0]  class_idx_o,
  output logic [DATA_W-1:0] class_score_o,
  input  logic              class_ready_i
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [IDX_W-1:0]          cnt_reg, cnt_next;
  logic signed [DATA_W-1:0]  best_reg, best_next;
  logic [IDX_W-1:0]          best_idx_reg, best_idx_next;
  logic                      ready_reg, ready_next;
  logic                      valid_reg, valid_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [DATA_W-1:0]         score_reg, score_next;

  logic accept;
  logic take;

  assign accept = dense_valid_i && ready_reg;

  // The first beat of a frame always wins; later beats only on a strictly
  // greater score, so ties keep the lower index.
  assign take = (cnt_reg == '0) || ($signed(dense_data_i) > best_reg);

  // State and datapath registers; reset clears everything, results included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ACCUM;
      cnt_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      ready_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      idx_reg      <= '0;
      score_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      ready_reg    <= ready_next;
      valid_reg    <= valid_next;
      idx_reg      <= idx_next;
      score_reg    <= score_next;
    end
  end

  // Next-state logic: clear overrides everything; otherwise accumulate beats
  // in ACCUM and wait for the result handshake in RESULT.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    ready_next    = ready_reg;
    valid_next    = valid_reg;
    idx_next      = idx_reg;
    score_next    = score_reg;

    if (clear_i) begin
      // Abort the frame; the last published result stays on the outputs.
      state_next = ACCUM;
      cnt_next   = '0;
      valid_next = 1'b0;
      ready_next = 1'b1;
    end else begin
      case (state_reg)
        ACCUM: begin
          ready_next = 1'b1;
          if (accept) begin
            if (take) begin
              best_next     = $signed(dense_data_i);
              best_idx_next = cnt_reg;
            end
            if (cnt_reg == LAST_IDX) begin
              // Publish the winner including this final beat's comparison.
              idx_next   = take ? cnt_reg : best_idx_reg;
              score_next = take ? dense_data_i : best_reg;
              valid_next = 1'b1;
              ready_next = 1'b0;
              cnt_next   = '0;
              state_next = RESULT;
            end else begin
              cnt_next = cnt_reg + IDX_W'(1);
            end
          end
        end
        RESULT: begin
          ready_next = 1'b0;
          if (valid_reg && class_ready_i) begin
            valid_next = 1'b0;
            ready_next = 1'b1;
            state_next = ACCUM;
          end
        end
        default: begin
          state_next = ACCUM;
          cnt_next   = '0;
          valid_next = 1'b0;
          ready_next = 1'b1;
        end
      endcase
    end
  end

  assign dense_ready_o = ready_reg;
  assign class_valid_o = valid_reg;
  assign class_idx_o   = idx_reg;
  assign class_score_o = score_reg;

endmodule

// File: tb/tb_dense_argmax.sv
// Directed testbench for dense_argmax with hand-computed expectations.
module tb_dense_argmax;

  localparam int N  = 40;
  localparam int DW = 32;
  localparam int IW = 6;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          dense_valid;
  logic [DW-1:0] dense_data;
  logic          dense_ready;
  logic          class_valid;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] class_score;
  logic          class_ready;

  int total;
  int bad;
  int hs_count;

  logic [DW-1:0] frame [N];

  dense_argmax #(
    .NUM_NEURONS(N),
    .DATA_W(DW),
    .IDX_W(IW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .dense_valid_i(dense_valid),
    .dense_data_i(dense_data),
    .dense_ready_o(dense_ready),
    .class_valid_o(class_valid),
    .class_idx_o(class_idx),
    .class_score_o(class_score),
    .class_ready_i(class_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted results; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n && class_valid && class_ready) hs_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic send_beat(input logic [DW-1:0] d);
    logic acc;
    acc = 1'b0;
    dense_valid = 1'b1;
    dense_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = dense_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("beat_accept_timeout", 0, 1);
  endtask

  // Send the first n beats of frame[]; optionally insert random idle cycles.
  task automatic run_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        dense_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(frame[i]);
    end
    dense_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [IW-1:0] idx, input logic [DW-1:0] score);
    check({tag, "_valid"}, class_valid, 1);
    check({tag, "_ready_low"}, dense_ready, 0);
    check({tag, "_idx"}, class_idx, idx);
    check({tag, "_score"}, class_score, score);
  endtask

  initial begin
    int hs_before;
    total = 0;
    bad = 0;
    hs_count = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    dense_valid = 1'b0;
    dense_data = '0;
    class_ready = 1'b1;

    // 1: reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_ready", dense_ready, 0);
    check("rst_valid", class_valid, 0);
    check("rst_idx", class_idx, 0);
    check("rst_score", class_score, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", dense_ready, 1);
    check("post_rst_valid", class_valid, 0);

    // 2: ascending ramp, max at the last beat
    for (int i = 0; i < N; i++) frame[i] = DW'(i * 3 - 50);
    run_frame(N, 0);
    check_result("ramp", 39, 32'd67);
    @(posedge clk);
    #1;
    check("ramp_valid_one_cycle", class_valid, 0);
    check("ramp_ready_back", dense_ready, 1);
    check("ramp_idx_held", class_idx, 39);

    // 3: all negative with a tie at 17 and 30
    for (int i = 0; i < N; i++) frame[i] = -32'sd100;
    frame[17] = -32'sd5;
    frame[30] = -32'sd5;
    run_frame(N, 0);
    check_result("neg_tie", 17, 32'hFFFF_FFFB);
    @(posedge clk);
    #1;

    // 4: back-pressure on the result with the source still pushing
    class_ready = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = DW'(i);
    frame[22] = 32'd1000;
    run_frame(N, 0);
    dense_valid = 1'b1;
    dense_data  = 32'h7FFF_FFFF;
    for (int c = 0; c < 20; c++) begin
      check_result("bp", 22, 32'd1000);
      @(posedge clk);
      #1;
    end
    class_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", class_valid, 0);
    check("bp_release_ready", dense_ready, 1);

    // 5: gapped input, max 0x7FFFFFFF at index 0 (held beat becomes beat 0)
    for (int i = 0; i < N; i++) frame[i] = DW'(i * 1000 - 7);
    frame[0]  = 32'h7FFF_FFFF;
    frame[20] = 32'h7FFF_FFFF;
    run_frame(N, 1);
    check_result("gap", 0, 32'h7FFF_FFFF);
    @(posedge clk);
    #1;

    // 6a: clear after beat 25, then a full frame with max at 4
    hs_before = hs_count;
    for (int i = 0; i < N; i++) frame[i] = 32'd5000 - DW'(i);
    run_frame(26, 0);
    clear = 1'b1;
    dense_valid = 1'b1;
    dense_data = 32'd9999;
    @(posedge clk);
    #1;
    clear = 1'b0;
    dense_valid = 1'b0;
    check("clr_valid", class_valid, 0);
    check("clr_ready", dense_ready, 1);
    check("clr_idx_kept", class_idx, 0);
    check("clr_score_kept", class_score, 32'h7FFF_FFFF);
    for (int i = 0; i < N; i++) frame[i] = DW'(-i);
    frame[4] = 32'd300;
    run_frame(N, 0);
    check_result("clr_frame", 4, 32'd300);
    @(posedge clk);
    #1;
    check("clr_one_result", hs_count - hs_before, 1);

    // 6b: reset pulse mid-frame, then a full frame with max at 4
    for (int i = 0; i < N; i++) frame[i] = DW'(i);
    frame[3] = 32'd8888;
    run_frame(15, 0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_ready", dense_ready, 0);
    check("mid_rst_idx", class_idx, 0);
    check("mid_rst_score", class_score, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs_before = hs_count;
    for (int i = 0; i < N; i++) frame[i] = DW'(-i);
    frame[4] = 32'd300;
    run_frame(N, 0);
    check_result("rst_frame", 4, 32'd300);
    @(posedge clk);
    #1;
    check("rst_one_result", hs_count - hs_before, 1);
    check("rst_final_valid", class_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
